// File: rtl/axi_check_adapter.sv
// Transparent AXI4 protocol monitor: wires s_axi_* straight to m_axi_* and watches the
// handshakes for outstanding-count, burst-length, valid-stability and stall violations.

module axi_check_lenq #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   cnt;
    logic          do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// One per channel: flags a valid withdrawn mid-stall and a stall reaching TIMEOUT cycles.
module axi_check_chan #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic ready,
    output logic fell,
    output logic timeout
);
    logic stall, prev_stall;

    assign stall = valid && !ready;
    assign fell  = prev_stall && !valid;

    always_ff @(posedge clk) begin
        if (rst) prev_stall <= 1'b0;
        else     prev_stall <= stall;
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int TW = $clog2(TIMEOUT + 1);
            logic [TW-1:0] cnt;
            // Fire on the edge the count lands on TIMEOUT, not every cycle it sits there.
            assign timeout = stall && (cnt == TW'(TIMEOUT - 1));
            always_ff @(posedge clk) begin
                if (rst || !stall)            cnt <= '0;
                else if (cnt != TW'(TIMEOUT)) cnt <= cnt + TW'(1);
            end
        end else begin : g_no_tmo
            assign timeout = 1'b0;
        end
    endgenerate
endmodule

module axi_check_adapter #(
    parameter int ID_WIDTH   = 10,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 6,
    parameter int MAX_OUTST  = 8,
    parameter int TIMEOUT    = 1024,
    localparam int CW = $clog2(MAX_OUTST) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    // upstream AW
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awregion,
    input  logic [3:0]              s_axi_awqos,
    input  logic [USER_WIDTH-1:0]   s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    // upstream W
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [USER_WIDTH-1:0]   s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    // upstream B
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [USER_WIDTH-1:0]   s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // upstream AR
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arregion,
    input  logic [3:0]              s_axi_arqos,
    input  logic [USER_WIDTH-1:0]   s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    // upstream R
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [USER_WIDTH-1:0]   s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // downstream AW
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awregion,
    output logic [3:0]              m_axi_awqos,
    output logic [USER_WIDTH-1:0]   m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    // downstream W
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic [USER_WIDTH-1:0]   m_axi_wuser,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    // downstream B
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic [USER_WIDTH-1:0]   m_axi_buser,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // downstream AR
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arregion,
    output logic [3:0]              m_axi_arqos,
    output logic [USER_WIDTH-1:0]   m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    // downstream R
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [USER_WIDTH-1:0]   m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    // monitor
    input  logic                    err_clear,
    output logic [5:0]              err_status,
    output logic                    err_irq,
    output logic [CW-1:0]           wr_outst,
    output logic [CW-1:0]           rd_outst
);
    assign m_axi_awid     = s_axi_awid;
    assign m_axi_awaddr   = s_axi_awaddr;
    assign m_axi_awlen    = s_axi_awlen;
    assign m_axi_awsize   = s_axi_awsize;
    assign m_axi_awburst  = s_axi_awburst;
    assign m_axi_awlock   = s_axi_awlock;
    assign m_axi_awcache  = s_axi_awcache;
    assign m_axi_awprot   = s_axi_awprot;
    assign m_axi_awregion = s_axi_awregion;
    assign m_axi_awqos    = s_axi_awqos;
    assign m_axi_awuser   = s_axi_awuser;
    assign m_axi_awvalid  = s_axi_awvalid;
    assign s_axi_awready  = m_axi_awready;
    assign m_axi_wdata    = s_axi_wdata;
    assign m_axi_wstrb    = s_axi_wstrb;
    assign m_axi_wlast    = s_axi_wlast;
    assign m_axi_wuser    = s_axi_wuser;
    assign m_axi_wvalid   = s_axi_wvalid;
    assign s_axi_wready   = m_axi_wready;
    assign s_axi_bid      = m_axi_bid;
    assign s_axi_bresp    = m_axi_bresp;
    assign s_axi_buser    = m_axi_buser;
    assign s_axi_bvalid   = m_axi_bvalid;
    assign m_axi_bready   = s_axi_bready;
    assign m_axi_arid     = s_axi_arid;
    assign m_axi_araddr   = s_axi_araddr;
    assign m_axi_arlen    = s_axi_arlen;
    assign m_axi_arsize   = s_axi_arsize;
    assign m_axi_arburst  = s_axi_arburst;
    assign m_axi_arlock   = s_axi_arlock;
    assign m_axi_arcache  = s_axi_arcache;
    assign m_axi_arprot   = s_axi_arprot;
    assign m_axi_arregion = s_axi_arregion;
    assign m_axi_arqos    = s_axi_arqos;
    assign m_axi_aruser   = s_axi_aruser;
    assign m_axi_arvalid  = s_axi_arvalid;
    assign s_axi_arready  = m_axi_arready;
    assign s_axi_rid      = m_axi_rid;
    assign s_axi_rdata    = m_axi_rdata;
    assign s_axi_rresp    = m_axi_rresp;
    assign s_axi_rlast    = m_axi_rlast;
    assign s_axi_ruser    = m_axi_ruser;
    assign s_axi_rvalid   = m_axi_rvalid;
    assign m_axi_rready   = s_axi_rready;

    localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);

    logic aw_hs, w_last_hs, w_hs, b_hs, ar_hs, r_last_hs;
    assign aw_hs     = s_axi_awvalid && m_axi_awready;
    assign w_hs      = s_axi_wvalid && m_axi_wready;
    assign w_last_hs = w_hs && s_axi_wlast;
    assign b_hs      = m_axi_bvalid && s_axi_bready;
    assign ar_hs     = s_axi_arvalid && m_axi_arready;
    assign r_last_hs = m_axi_rvalid && s_axi_rready && m_axi_rlast;

    always_ff @(posedge clk) begin
        if (rst)                                          wr_outst <= '0;
        else if (aw_hs && !b_hs && wr_outst != OUTST_MAX) wr_outst <= wr_outst + CW'(1);
        else if (b_hs && !aw_hs && wr_outst != '0)        wr_outst <= wr_outst - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)                                               rd_outst <= '0;
        else if (ar_hs && !r_last_hs && rd_outst != OUTST_MAX) rd_outst <= rd_outst + CW'(1);
        else if (r_last_hs && !ar_hs && rd_outst != '0)        rd_outst <= rd_outst - CW'(1);
    end

    // W beats seen so far in the current burst; at wlast this equals beats-1, i.e. awlen.
    logic [7:0] wbeat;
    always_ff @(posedge clk) begin
        if (rst)       wbeat <= '0;
        else if (w_hs) wbeat <= s_axi_wlast ? 8'd0 : wbeat + 8'd1;
    end

    logic [7:0] aw_head, w_head;
    logic       aw_empty, aw_full, w_empty, w_full, cmp;
    assign cmp = !aw_empty && !w_empty;

    axi_check_lenq #(.DEPTH(MAX_OUTST)) u_aw_q (
        .clk(clk), .rst(rst), .push(aw_hs), .din(s_axi_awlen), .pop(cmp),
        .dout(aw_head), .empty(aw_empty), .full(aw_full)
    );
    axi_check_lenq #(.DEPTH(MAX_OUTST)) u_w_q (
        .clk(clk), .rst(rst), .push(w_last_hs), .din(wbeat), .pop(cmp),
        .dout(w_head), .empty(w_empty), .full(w_full)
    );

    logic [4:0] ch_vld, ch_rdy, ch_fell, ch_tmo;
    assign ch_vld = {s_axi_awvalid, s_axi_wvalid, m_axi_bvalid, s_axi_arvalid, m_axi_rvalid};
    assign ch_rdy = {m_axi_awready, m_axi_wready, s_axi_bready, m_axi_arready, s_axi_rready};

    axi_check_chan #(.TIMEOUT(TIMEOUT)) u_chan [4:0] (
        .clk(clk), .rst(rst), .valid(ch_vld), .ready(ch_rdy),
        .fell(ch_fell), .timeout(ch_tmo)
    );

    logic [5:0] err_set;
    assign err_set[0] = b_hs && (wr_outst == '0);
    assign err_set[1] = r_last_hs && (rd_outst == '0);
    assign err_set[2] = (aw_hs && (wr_outst == OUTST_MAX)) || (ar_hs && (rd_outst == OUTST_MAX))
                     || (aw_hs && aw_full) || (w_last_hs && w_full);
    assign err_set[3] = cmp && (aw_head != w_head);
    assign err_set[4] = |ch_fell;
    assign err_set[5] = |ch_tmo;

    // A new error on the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (rst) err_status <= '0;
        else     err_status <= (err_clear ? 6'd0 : err_status) | err_set;
    end

    assign err_irq = |err_status;
endmodule
